// File: rtl/ram_lsu_pkg.sv
// ram_lsu_pkg
//   Shared types and lane helpers for the RAM load/store unit.
//   size_e  : access size encoding as seen on req_size_i.
//   state_e : LSU sequencing states.
//   store_be / store_dat : byte-enable and replicated write data for stores.
//   load_fmt             : lane select and sign/zero extension for loads.
package ram_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } state_e;

    function automatic logic [3:0] store_be(input size_e size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Data is replicated across all lanes so the byte enables alone pick the target.
    function automatic logic [31:0] store_dat(input size_e size, input logic [31:0] wdata);
        logic [31:0] dat;
        case (size)
            SZ_BYTE: dat = {4{wdata[7:0]}};
            SZ_HALF: dat = {2{wdata[15:0]}};
            default: dat = wdata;
        endcase
        return dat;
    endfunction

    function automatic logic [31:0] load_fmt(input size_e size, input logic sgn,
                                             input logic [1:0] addr_lo, input logic [31:0] word);
        logic [31:0] res;
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h00;
        h = 16'h0000;
        case (addr_lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = {{24{sgn & b[7]}}, b};
            SZ_HALF: res = {{16{sgn & h[15]}}, h};
            SZ_WORD: res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ram_lsu_lane.sv
// ram_lsu_lane
//   Combinational load formatter: selects the addressed byte/half lane of the
//   returned RAM word and sign- or zero-extends it (word loads pass through).
//   size    in  access size
//   sgn     in  1 = sign-extend
//   addr_lo in  byte offset within the word
//   word    in  raw RAM read data
//   data    out formatted load result
module ram_lsu_lane
    import ram_lsu_pkg::*;
(
    input  size_e       size,
    input  logic        sgn,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    always_comb begin
        data = load_fmt(size, sgn, addr_lo, word);
    end

endmodule

// File: rtl/ram_lsu.sv
// ram_lsu
//   Single-outstanding load/store initiator for the on-chip single-port RAM
//   (registered 1-cycle read). Accepts one byte/half/word request, drives the
//   RAM port, formats the load lane and returns one response.
//   Optional build macro: RAM_LSU_ALIGN_CHECK_EN -- when defined, misaligned
//   half/word accesses return an error instead of accessing the RAM.
//   Ports:
//     clk_i, rst_n_i (synchronous, active-low)
//     req_valid_i/req_ready_o, req_we_i, req_size_i, req_signed_i,
//     req_addr_i, req_wdata_i                -- request
//     rsp_valid_o/rsp_ready_i, rsp_rdata_o, rsp_err_o -- response
//     ram_we_o, ram_adr_o, ram_be_o, ram_dat_o, ram_dat_i -- RAM port
module ram_lsu
    import ram_lsu_pkg::*;
#(
    parameter int          WORD_ADR_W = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  ram_we_o,
    output logic [WORD_ADR_W-1:0] ram_adr_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_dat_o,
    input  logic [31:0]           ram_dat_i
);

    // state   | meaning
    // IDLE    | ready for a request
    // ISSUE   | RAM port driven (store writes this cycle, load address sampled)
    // CAPTURE | load data from RAM is formatted and registered
    // RESP    | response valid, waiting for rsp_ready_i

    state_e      state;
    state_e      state_nxt;

    logic        accept;
    logic [31:0] offset;
    logic        range_err;
    logic        size_err;
    logic        align_err;
    logic        req_err;
    size_e       req_size;

    logic        op_we;
    size_e       op_size;
    logic        op_signed;
    logic [1:0]  op_lo;
    logic [31:0] lane_data;

    assign req_size = size_e'(req_size_i);
    assign accept   = req_valid_i && req_ready_o;

    // Unsigned offset: addresses below BASE_ADDR wrap to large values and fail the range test.
    assign offset    = req_addr_i - BASE_ADDR;
    assign range_err = |offset[31:WORD_ADR_W+2];
    assign size_err  = (req_size == SZ_ILL);

`ifdef RAM_LSU_ALIGN_CHECK_EN
    assign align_err = ((req_size == SZ_HALF) && req_addr_i[0]) ||
                       ((req_size == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
`else
    assign align_err = 1'b0;
`endif

    assign req_err = size_err || range_err || align_err;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (accept) begin
                    state_nxt = req_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = op_we ? RESP : CAPTURE;
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    ram_lsu_lane u_lane (
        .size    (op_size),
        .sgn     (op_signed),
        .addr_lo (op_lo),
        .word    (ram_dat_i),
        .data    (lane_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ram_we_o    <= 1'b0;
            ram_be_o    <= 4'b0000;
            ram_adr_o   <= '0;
            ram_dat_o   <= 32'h0;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
            op_we       <= 1'b0;
            op_size     <= SZ_BYTE;
            op_signed   <= 1'b0;
            op_lo       <= 2'b00;
        end else begin
            // Write strobe and enables only live for the single ISSUE cycle.
            ram_we_o <= 1'b0;
            ram_be_o <= 4'b0000;
            if (accept) begin
                rsp_err_o   <= req_err;
                rsp_rdata_o <= 32'h0;
                if (!req_err) begin
                    ram_adr_o <= offset[WORD_ADR_W+1:2];
                    op_we     <= req_we_i;
                    op_size   <= req_size;
                    op_signed <= req_signed_i;
                    op_lo     <= req_addr_i[1:0];
                    if (req_we_i) begin
                        ram_we_o  <= 1'b1;
                        ram_be_o  <= store_be(req_size, req_addr_i[1:0]);
                        ram_dat_o <= store_dat(req_size, req_wdata_i);
                    end else begin
                        ram_dat_o <= 32'h0;
                    end
                end
            end
            if (state == CAPTURE) begin
                rsp_rdata_o <= lane_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_lsu.sv
module tb_ram_lsu;

    localparam int W = 12;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_signed_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        ram_we_o;
    logic [W-1:0] ram_adr_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_dat_o;
    logic [31:0] ram_dat_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ram_lsu #(.WORD_ADR_W(W), .BASE_ADDR(32'h0)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_size_i(req_size_i), .req_signed_i(req_signed_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .ram_we_o(ram_we_o), .ram_adr_o(ram_adr_o), .ram_be_o(ram_be_o),
        .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i)
    );

    // On-chip RAM model: byte-enabled write, registered read.
    logic [31:0] mem [4096];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0] = 32'h3c01a000;
        mem[1] = 32'h34210080;
    end
    always @(posedge clk_i) begin
        if (ram_we_o) begin
            for (int i = 0; i < 4; i++)
                if (ram_be_o[i]) mem[ram_adr_o][8*i +: 8] <= ram_dat_o[8*i +: 8];
        end
        ram_dat_i <= mem[ram_adr_o];
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [3:0]  exp_be;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [1:0] size, logic sgn, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_err,
                                int exp_lat, logic [3:0] exp_be, logic [31:0] exp_dat);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_be = exp_be; v.exp_dat = exp_dat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
        req_signed_i = sgn; req_addr_i = addr; req_wdata_i = wdata;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int we_cnt;
        logic [3:0]  cap_be;
        logic [31:0] cap_dat;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk_i);
        chk({tag, "_ready"}, {31'b0, req_ready_o}, 32'd1);
        drive(v.we, v.size, v.sgn, v.addr, v.wdata);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        cyc = 1; we_cnt = 0; cap_be = 4'h0; cap_dat = 32'h0;
        while (!rsp_valid_o && cyc < 20) begin
            if (ram_we_o) begin
                we_cnt++; cap_be = ram_be_o; cap_dat = ram_dat_o;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        chk({tag, "_lat"}, cyc, v.exp_lat);
        chk({tag, "_rdata"}, rsp_rdata_o, v.exp_rdata);
        chk({tag, "_err"}, {31'b0, rsp_err_o}, {31'b0, v.exp_err});
        chk({tag, "_we_cycles"}, we_cnt, (v.we && !v.exp_err) ? 1 : 0);
        if (v.we && !v.exp_err) begin
            chk({tag, "_be"}, {28'b0, cap_be}, {28'b0, v.exp_be});
            chk({tag, "_dat"}, cap_dat, v.exp_dat);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        chk({tag, "_done"}, {31'b0, rsp_valid_o}, 32'd0);
    endtask

    initial begin
        logic bad;
        int   cyc;
        logic [31:0] exp_q [4];

        // 0 byte, 1 half, 2 word, 3 illegal
        vecs.push_back(mk(0, 2'b00, 1, 32'h1, 0, 32'hFFFF_FFA0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h2, 0, 32'h0000_3C01, 0, 3, 0, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h0, 0, 32'h3C01_A000, 0, 3, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h1, 0, 32'h0000_00A0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h0, 0, 32'hFFFF_A000, 0, 3, 0, 0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h4, 0, 32'hFFFF_FF80, 0, 3, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h6, 0, 32'h0000_3421, 0, 3, 0, 0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h7, 32'hAABB_CC55, 0, 0, 2, 4'b1000, 32'h5555_5555));
        vecs.push_back(mk(0, 2'b10, 0, 32'h4, 0, 32'h5521_0080, 0, 3, 0, 0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h8, 32'hFFFF_BEEF, 0, 0, 2, 4'b0011, 32'hBEEF_BEEF));
        vecs.push_back(mk(1, 2'b01, 0, 32'hA, 32'h0000_1234, 0, 0, 2, 4'b1100, 32'h1234_1234));
        vecs.push_back(mk(0, 2'b10, 0, 32'h8, 0, 32'h1234_BEEF, 0, 3, 0, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'hC, 32'hDEAD_BEEF, 0, 0, 2, 4'b1111, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 2'b00, 1, 32'hF, 0, 32'hFFFF_FFDE, 0, 3, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'hE, 0, 32'h0000_DEAD, 0, 3, 0, 0));
`ifdef RAM_LSU_ALIGN_CHECK_EN
        vecs.push_back(mk(0, 2'b10, 0, 32'h6, 0, 32'h0, 1, 1, 0, 0));
`else
        vecs.push_back(mk(0, 2'b10, 0, 32'h6, 0, 32'h5521_0080, 0, 3, 0, 0));
`endif
        vecs.push_back(mk(0, 2'b10, 0, 32'h4000, 0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h0, 0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h4000, 32'h1111_2222, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h3FFC, 0, 32'h0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'hFFFF_FFFC, 0, 32'h0, 1, 1, 0, 0));

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_err", {31'b0, rsp_err_o}, 32'd0);
        chk("rst_we", {31'b0, ram_we_o}, 32'd0);
        chk("rst_be", {28'b0, ram_be_o}, 32'd0);
        chk("rst_adr", {20'b0, ram_adr_o}, 32'd0);
        chk("rst_dat", ram_dat_o, 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Error response held stable while rsp_ready_i is low
        @(negedge clk_i);
        drive(0, 2'b10, 0, 32'h4000, 0);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0 || ram_we_o !== 1'b0)
                bad = 1'b1;
            @(posedge clk_i); #1;
        end
        chk("hold_stable", {31'b0, bad}, 32'd0);
        chk("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        chk("hold_release", {31'b0, rsp_valid_o}, 32'd0);

        // Reset asserted during CAPTURE
        @(negedge clk_i);
        drive(0, 2'b10, 0, 32'h0, 0);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b0;
        bad = 1'b0;
        repeat (2) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o !== 1'b0) bad = 1'b1;
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (4) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o !== 1'b0) bad = 1'b1;
        end
        chk("midrst_no_rsp", {31'b0, bad}, 32'd0);
        chk("midrst_ready", {31'b0, req_ready_o}, 32'd1);

        // Back-to-back requests with rsp_ready_i held high
        exp_q[0] = 32'h3C01_A000;
        exp_q[1] = 32'h0;
        exp_q[2] = 32'h3C01_A011;
        exp_q[3] = 32'h0000_003C;
        rsp_ready_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk_i);
            cyc = 0;
            while (!req_ready_o && cyc < 10) begin
                @(negedge clk_i);
                cyc++;
            end
            chk($sformatf("b2b%0d_ready", n), {31'b0, req_ready_o}, 32'd1);
            case (n)
                0: drive(0, 2'b10, 0, 32'h0, 0);
                1: drive(1, 2'b00, 0, 32'h0, 32'h0000_0011);
                2: drive(0, 2'b10, 0, 32'h0, 0);
                default: drive(0, 2'b00, 0, 32'h3, 0);
            endcase
            @(posedge clk_i); #1;
            req_valid_i = 1'b0;
            cyc = 0;
            while (!rsp_valid_o && cyc < 10) begin
                @(posedge clk_i); #1;
                cyc++;
            end
            chk($sformatf("b2b%0d_valid", n), {31'b0, rsp_valid_o}, 32'd1);
            chk($sformatf("b2b%0d_rdata", n), rsp_rdata_o, exp_q[n]);
            chk($sformatf("b2b%0d_busy", n), {31'b0, req_ready_o}, 32'd0);
        end
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        chk("b2b_done", {31'b0, rsp_valid_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
